// File: rtl/pcie_perst_gen.sv
`timescale 1ns/1ps
// PCIe fundamental reset (PERST#) generator: cold power-up release, CPU warm resets,
// immediate assertion on power loss. All timing is counted in 1 ms ticks.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// IDLE        | power not good, PERST# held low
// PWR_WAIT    | power good, counting PWR_DLY_MS before first release
// RUN         | PERST# released, link may train
// WARM_ASSERT | CPU warm reset, PERST# held low for ASSERT_MS
// WARM_HOLD   | minimum assert time done, waiting for the request to drop
module pcie_perst_gen #(
    parameter int PWR_DLY_MS = 100,
    parameter int ASSERT_MS  = 20,
    parameter int CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       int_1ms_en,
    input  logic       cpua_pwrok,
    input  logic       slot_pwrgd,
    input  logic       sw_rst_req,
    output logic       perst_n,
    output logic       pcie_rdy,
    output logic [7:0] warm_cnt
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PWR_WAIT    = 3'd1,
        RUN         = 3'd2,
        WARM_ASSERT = 3'd3,
        WARM_HOLD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_PWR_DLY = PWR_DLY_MS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LP_ASSERT  = ASSERT_MS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LP_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LP_MAX     = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwrok_s1, r_pwrok_s2;
    logic             r_pwrgd_s1, r_pwrgd_s2;
    logic             r_req_s1, r_req_s2, r_req_s3;
    logic             r_perst_n;
    logic             r_pcie_rdy;
    logic [7:0]       r_warm_cnt;
    logic             w_pwr_ok;
    logic             w_req_rise;
    logic             w_warm_inc;
    logic             w_timed;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pwrok_s1 <= 1'b0;
            r_pwrok_s2 <= 1'b0;
            r_pwrgd_s1 <= 1'b0;
            r_pwrgd_s2 <= 1'b0;
            r_req_s1   <= 1'b0;
            r_req_s2   <= 1'b0;
            r_req_s3   <= 1'b0;
        end else begin
            r_pwrok_s1 <= cpua_pwrok;
            r_pwrok_s2 <= r_pwrok_s1;
            r_pwrgd_s1 <= slot_pwrgd;
            r_pwrgd_s2 <= r_pwrgd_s1;
            r_req_s1   <= sw_rst_req;
            r_req_s2   <= r_req_s1;
            r_req_s3   <= r_req_s2;
        end
    end

    assign w_pwr_ok   = r_pwrok_s2 & r_pwrgd_s2;
    assign w_req_rise = r_req_s2 & ~r_req_s3;
    assign w_timed    = (r_state == PWR_WAIT) || (r_state == WARM_ASSERT);

    // Power loss is tested first in every state so it wins over any other event.
    always_comb begin
        w_next     = r_state;
        w_warm_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pwr_ok) w_next = PWR_WAIT;
            end
            PWR_WAIT: begin
                if (!w_pwr_ok)                w_next = IDLE;
                else if (r_cnt == LP_PWR_DLY) w_next = RUN;
            end
            RUN: begin
                if (!w_pwr_ok) begin
                    w_next = IDLE;
                end else if (w_req_rise) begin
                    w_next     = WARM_ASSERT;
                    w_warm_inc = 1'b1;
                end
            end
            WARM_ASSERT: begin
                if (!w_pwr_ok)               w_next = IDLE;
                else if (r_cnt == LP_ASSERT) w_next = r_req_s2 ? WARM_HOLD : RUN;
            end
            WARM_HOLD: begin
                if (!w_pwr_ok)     w_next = IDLE;
                else if (!r_req_s2) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_perst_n  <= 1'b0;
            r_pcie_rdy <= 1'b0;
            r_warm_cnt <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_perst_n  <= (w_next == RUN);
            r_pcie_rdy <= (w_next == RUN);
            // Counter restarts on every state entry and holds at full scale rather than wrapping.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (int_1ms_en && w_timed && (r_cnt != LP_MAX))
                r_cnt <= r_cnt + LP_ONE;
            if (w_warm_inc && (r_warm_cnt != 8'hFF))
                r_warm_cnt <= r_warm_cnt + 8'd1;
        end
    end

    assign perst_n  = r_perst_n;
    assign pcie_rdy = r_pcie_rdy;
    assign warm_cnt = r_warm_cnt;

endmodule

// File: tb/tb_pcie_perst_gen.sv
`timescale 1ns/1ps
// Bench for pcie_perst_gen: directed stimulus pushes expected output transitions with
// cycle windows into a queue; a monitor pops and checks each perst_n/pcie_rdy change.
module tb_pcie_perst_gen;

    localparam int PWR = 100;
    localparam int ASR = 20;

    typedef struct {
        logic       perst;
        logic       rdy;
        logic [7:0] wcnt;
        int         lo;
        int         hi;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       int_1ms_en;
    logic       cpua_pwrok;
    logic       slot_pwrgd;
    logic       sw_rst_req;
    logic       perst_n;
    logic       pcie_rdy;
    logic [7:0] warm_cnt;

    int         cyc = 0;
    int         tick_period = 10;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_wcnt = 8'd0;
    exp_t       q[$];
    string      qn[$];
    logic       m_perst = 1'b0;
    logic       m_rdy = 1'b0;

    pcie_perst_gen #(.PWR_DLY_MS(PWR), .ASSERT_MS(ASR), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .int_1ms_en (int_1ms_en),
        .cpua_pwrok (cpua_pwrok),
        .slot_pwrgd (slot_pwrgd),
        .sw_rst_req (sw_rst_req),
        .perst_n    (perst_n),
        .pcie_rdy   (pcie_rdy),
        .warm_cnt   (warm_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        int_1ms_en = 1'b0;
        forever begin
            repeat (tick_period - 1) @(negedge clock);
            int_1ms_en = 1'b1;
            @(negedge clock);
            int_1ms_en = 1'b0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic chk_win(input string n, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: change at cycle %0d, expected cycle %0d..%0d", n, act, lo, hi);
        end
    endtask

    task automatic push_exp(input logic p, input logic r, input logic [7:0] w,
                            input int lo, input int hi, input string n);
        exp_t e;
        e.perst = p;
        e.rdy   = r;
        e.wcnt  = w;
        e.lo    = lo;
        e.hi    = hi;
        q.push_back(e);
        qn.push_back(n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Timed exit window: state entered 3 edges after the pin change at cycle c.
    function automatic int tmr_lo(input int c, input int n);
        return c + 3 + 2 + (n - 1) * tick_period;
    endfunction

    function automatic int tmr_hi(input int c, input int n);
        return c + 3 + 1 + n * tick_period;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    task automatic warm_pulse(input int width, input string n);
        int c;
        c = cyc;
        sw_rst_req = 1'b1;
        exp_wcnt = sat_inc(exp_wcnt);
        push_exp(1'b0, 1'b0, exp_wcnt, c + 3, c + 3, {n, "_assert"});
        push_exp(1'b1, 1'b1, exp_wcnt, tmr_lo(c, ASR), tmr_hi(c, ASR), {n, "_release"});
        idle(width);
        sw_rst_req = 1'b0;
        wait_cyc(tmr_hi(c, ASR) + 3);
    endtask

    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clock);
            if (perst_n !== m_perst || pcie_rdy !== m_rdy) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_change: perst_n=%b pcie_rdy=%b at cycle %0d, expected no change",
                             perst_n, pcie_rdy, cyc);
                end else begin
                    e  = q.pop_front();
                    nm = qn.pop_front();
                    chk({nm, "_perst_n"}, perst_n, e.perst);
                    chk({nm, "_pcie_rdy"}, pcie_rdy, e.rdy);
                    chk({nm, "_warm_cnt"}, warm_cnt, e.wcnt);
                    chk_win({nm, "_time"}, cyc, e.lo, e.hi);
                end
                m_perst = perst_n;
                m_rdy   = pcie_rdy;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int c;
        reset      = 1'b0;
        cpua_pwrok = 1'b0;
        slot_pwrgd = 1'b0;
        sw_rst_req = 1'b0;
        idle(3);
        chk("reset_perst_n", perst_n, 1'b0);
        chk("reset_pcie_rdy", pcie_rdy, 1'b0);
        chk("reset_warm_cnt", warm_cnt, 8'd0);
        reset = 1'b1;
        idle(20);

        // cold boot
        c = cyc;
        cpua_pwrok = 1'b1;
        slot_pwrgd = 1'b1;
        push_exp(1'b1, 1'b1, exp_wcnt, tmr_lo(c, PWR), tmr_hi(c, PWR), "cold_boot");
        wait_cyc(tmr_hi(c, PWR) + 2);

        warm_pulse(5, "warm");

        // request held longer than the minimum assert time
        c = cyc;
        sw_rst_req = 1'b1;
        exp_wcnt = sat_inc(exp_wcnt);
        push_exp(1'b0, 1'b0, exp_wcnt, c + 3, c + 3, "held_assert");
        idle(50 * tick_period);
        c = cyc;
        sw_rst_req = 1'b0;
        push_exp(1'b1, 1'b1, exp_wcnt, c + 3, c + 3, "held_release");
        idle(10);

        // CPU power loss in RUN, then slot power glitch 40 ms into the wait
        c = cyc;
        cpua_pwrok = 1'b0;
        push_exp(1'b0, 1'b0, exp_wcnt, c + 3, c + 3, "pwrok_loss_run");
        idle(10);
        sw_rst_req = 1'b1;
        idle(10);
        cpua_pwrok = 1'b1;
        idle(40 * tick_period);
        slot_pwrgd = 1'b0;
        idle(10);
        c = cyc;
        slot_pwrgd = 1'b1;
        push_exp(1'b1, 1'b1, exp_wcnt, tmr_lo(c, PWR), tmr_hi(c, PWR), "pwrgd_restart");
        wait_cyc(tmr_hi(c, PWR) + 2);
        idle(30 * tick_period);
        sw_rst_req = 1'b0;
        idle(10);

        // power loss in the same cycle as a request edge
        c = cyc;
        sw_rst_req = 1'b1;
        cpua_pwrok = 1'b0;
        push_exp(1'b0, 1'b0, exp_wcnt, c + 3, c + 3, "loss_with_req");
        idle(10);
        sw_rst_req = 1'b0;
        idle(5);
        c = cyc;
        cpua_pwrok = 1'b1;
        push_exp(1'b1, 1'b1, exp_wcnt, tmr_lo(c, PWR), tmr_hi(c, PWR), "loss_recover");
        wait_cyc(tmr_hi(c, PWR) + 2);

        // warm count saturation, with a fast tick to keep the run short
        tick_period = 2;
        idle(20);
        for (int i = 0; i < 260; i++) warm_pulse(3, "sat");
        chk("sat_final", warm_cnt, 8'd255);

        // async reset in the middle of a warm reset
        tick_period = 10;
        idle(30);
        c = cyc;
        sw_rst_req = 1'b1;
        exp_wcnt = sat_inc(exp_wcnt);
        push_exp(1'b0, 1'b0, exp_wcnt, c + 3, c + 3, "midop_assert");
        idle(3);
        sw_rst_req = 1'b0;
        idle(5 * tick_period);
        #2;
        reset = 1'b0;
        #1;
        chk("midop_perst_n", perst_n, 1'b0);
        chk("midop_pcie_rdy", pcie_rdy, 1'b0);
        chk("midop_warm_cnt", warm_cnt, 8'd0);
        idle(5);
        c = cyc;
        reset = 1'b1;
        exp_wcnt = 8'd0;
        push_exp(1'b1, 1'b1, exp_wcnt, tmr_lo(c, PWR), tmr_hi(c, PWR), "midop_cold");
        wait_cyc(tmr_hi(c, PWR) + 2);

        idle(20);
        chk("pending_events", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
